uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage, the downstream counterpart of the transmit block. It samples the asynchronous rx line at mid-bit using a clock-cycle bit timer and recovers 8N1 frames (start bit, 8 data bits LSB first, stop bit). Each good byte is presented as a one-cycle valid pulse to the consuming logic, and framing faults are flagged.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_receiver_if.sv | 29 ++
 rtl/uart_sync_2ff.sv | 27 ++
 rtl/uart_receiver.sv | 165 ++++++++++++++++
 tb/tb_uart_receiver.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, bit-period helper and timer width.
package uart_pkg;

  // Bit timer width, also used by the transmit block.
  localparam int unsigned TimerWidth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned calc_clk_per_bit(input int unsigned baud_rate,
                                                   input int unsigned clock_frequency);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle: serial line in, recovered byte and status pulses out.
interface uart_receiver_if;
  logic       rx_serial;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       parity_error;
  logic       busy;

  // Receiver side.
  modport master (
    input  rx_serial,
    output data,
    output valid,
    output framing_error,
    output parity_error,
    output busy
  );

  // Line driver / byte consumer side.
  modport slave (
    output rx_serial,
    input  data,
    input  valid,
    input  framing_error,
    input  parity_error,
    input  busy
  );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; both stages reset to the line's idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: mid-bit sampling of 8N1 frames (8E1 when UART_RX_PARITY_EN is defined),
// one-cycle valid / framing_error / parity_error pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned BaudRate       = 115200,
  parameter int unsigned ClockFrequency = 100000000
) (
  input logic             clk,
  input logic             rst,
  uart_receiver_if.master rx_if
);

  localparam int unsigned ClkPerBit = calc_clk_per_bit(BaudRate, ClockFrequency);
  localparam logic [TimerWidth-1:0] BitLast  = TimerWidth'(ClkPerBit - 1);
  localparam logic [TimerWidth-1:0] HalfLast = TimerWidth'(ClkPerBit / 2 - 1);

  logic                  rx_s;
  logic                  rx_prev_q;
  rx_state_e             state_q, state_d;
  logic [TimerWidth-1:0] t_count_q, t_count_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  framing_error_q, framing_error_d;
`ifdef UART_RX_PARITY_EN
  logic                  parity_bit_q, parity_bit_d;
  logic                  parity_error_q, parity_error_d;
`endif
  logic                  tick;

  uart_sync_2ff #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(rx_if.rx_serial),
    .q_o(rx_s)
  );

  // START waits half a bit to land mid start bit; other states wait a full bit.
  assign tick = (state_q == StStart) ? (t_count_q == HalfLast) : (t_count_q == BitLast);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_q       <= 1'b1;
      state_q         <= StIdle;
      t_count_q       <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q    <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      rx_prev_q       <= rx_s;
      state_q         <= state_d;
      t_count_q       <= t_count_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      framing_error_q <= framing_error_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q    <= parity_bit_d;
      parity_error_q  <= parity_error_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rx_prev_q && !rx_s) state_d = StStart;
      StStart: if (tick) state_d = rx_s ? StIdle : StData;
      StData: begin
        if (tick && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (tick) state_d = StStop;
`endif
      // Return at mid stop bit so a back-to-back start edge is not missed.
      StStop:  if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Timer, shift register, captured byte and status pulses.
  always_comb begin
    t_count_d       = t_count_q + 1'b1;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    data_d          = data_q;
    valid_d         = 1'b0;
    framing_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_d    = parity_bit_q;
    parity_error_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        t_count_d = '0;
        bit_idx_d = '0;
      end
      StStart: if (tick) t_count_d = '0;
      StData: begin
        if (tick) begin
          t_count_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q != 3'd7) bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          t_count_d    = '0;
          parity_bit_d = rx_s;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          t_count_d = '0;
          if (!rx_s) begin
            framing_error_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if ((^shift_q) != parity_bit_q) begin
            parity_error_d = 1'b1;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: t_count_d = '0;
    endcase
  end

  // Output drive.
  always_comb begin
    rx_if.data          = data_q;
    rx_if.valid         = valid_q;
    rx_if.framing_error = framing_error_q;
`ifdef UART_RX_PARITY_EN
    rx_if.parity_error  = parity_error_q;
`else
    rx_if.parity_error  = 1'b0;
`endif
    rx_if.busy          = (state_q != StIdle);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames against a
// frame-level model (expected pulse kind, byte and cycle per transmitted frame).
module tb_uart_receiver;

  localparam int unsigned ClockFrequency = 1600000;
  localparam int unsigned BaudRate       = 100000;
  localparam int          Cpb            = ClockFrequency / BaudRate;
`ifdef UART_RX_PARITY_EN
  localparam bit ParityEn  = 1'b1;
  localparam int FrameBits = 10;
`else
  localparam bit ParityEn  = 1'b0;
  localparam int FrameBits = 9;
`endif
  // Pulse cycle relative to the line's falling edge: 2 sync cycles, half bit,
  // start+data(+parity) bits to the stop sample, then one registered cycle.
  localparam int PulseLat = 2 + Cpb / 2 + FrameBits * Cpb + 1;

  typedef struct {
    int         kind;  // 0 good byte, 1 framing error, 2 parity error
    logic [7:0] data;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic [7:0] model_data = 8'h00;

  uart_receiver_if bus ();

  uart_receiver #(
    .BaudRate(BaudRate),
    .ClockFrequency(ClockFrequency)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_if(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Hold the line at v for n cycles; callers stay aligned at posedge+1.
  task automatic hold(input logic v, input int n);
    bus.rx_serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bad,
                            input int low_tail, input int gap);
    exp_t e;
    e.data = b;
    e.at   = cyc + PulseLat;
    e.kind = !stop_bit ? 1 : ((ParityEn && par_bad) ? 2 : 0);
    exp_q.push_back(e);
    hold(1'b0, Cpb);
    for (int i = 0; i < 8; i++) hold(b[i], Cpb);
    if (ParityEn) hold((^b) ^ par_bad, Cpb);
    hold(stop_bit, Cpb);
    if (low_tail > 0) hold(1'b0, low_tail);
    hold(1'b1, gap);
  endtask

  // Wait (bounded) for all expected pulses, then check idle state and held data.
  task automatic settle(input string tag);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.busy); i++) @(negedge clk);
    check_eq({tag, "_pending"}, 32'(exp_q.size()), 0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_data"}, 32'(bus.data), 32'(model_data));
    @(posedge clk);
    #1;
  endtask

  // Pulse monitor against the expected-event queue.
  always @(negedge clk) begin : mon
    int   npulse;
    int   kind;
    exp_t e;
    if (!rst) begin
      npulse = int'(bus.valid) + int'(bus.framing_error) + int'(bus.parity_error);
      if (npulse != 0) begin
        check_eq("pulse_onehot", 32'(npulse), 1);
        kind = bus.valid ? 0 : (bus.framing_error ? 1 : 2);
        check_eq("pulse_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("pulse_kind", 32'(kind), 32'(e.kind));
          check_eq("pulse_cycle", 32'(cyc), 32'(e.at));
          if (e.kind == 0) model_data = e.data;
          check_eq("pulse_data", 32'(bus.data), 32'(model_data));
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       stop_bit;
    logic       par_bad;
    int         gap;
    int         tail;

    bus.rx_serial = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", 32'(bus.data), 0);
    check_eq("rst_valid", 32'(bus.valid), 0);
    check_eq("rst_ferr", 32'(bus.framing_error), 0);
    check_eq("rst_perr", 32'(bus.parity_error), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    hold(1'b1, 5);

    send_frame(8'hA5, 1'b1, 1'b0, 0, 10);
    settle("a5");
    send_frame(8'h3C, 1'b1, 1'b0, 0, 10);
    settle("3c");

    // Framing error, with the line left low afterwards: no false restart.
    send_frame(8'h11, 1'b1, 1'b0, 0, 10);
    send_frame(8'h3C, 1'b0, 1'b0, 40, 10);
    settle("ferr");

    // Short low glitch on the line.
    hold(1'b0, 5);
    check_eq("glitch_busy", 32'(bus.busy), 1);
    hold(1'b1, 60);
    settle("glitch");

    // Back-to-back frames, 1-bit stop.
    send_frame(8'h00, 1'b1, 1'b0, 0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0, 5);
    settle("b2b");

    // Reset during data bit 4 of 0x77.
    b = 8'h77;
    hold(1'b0, Cpb);
    for (int i = 0; i < 4; i++) hold(b[i], Cpb);
    hold(b[4], Cpb / 2);
    rst = 1'b1;
    #1;
    model_data = 8'h00;
    check_eq("mid_rst_data", 32'(bus.data), 0);
    check_eq("mid_rst_valid", 32'(bus.valid), 0);
    check_eq("mid_rst_ferr", 32'(bus.framing_error), 0);
    check_eq("mid_rst_busy", 32'(bus.busy), 0);
    bus.rx_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    hold(1'b1, 20);
    send_frame(8'h5A, 1'b1, 1'b0, 0, 10);
    settle("after_rst");

    if (ParityEn) begin
      send_frame(8'h07, 1'b1, 1'b1, 0, 10);
      settle("par_bad");
      send_frame(8'h07, 1'b1, 1'b0, 0, 10);
      settle("par_good");
    end

    // Random frames.
    for (int n = 0; n < 40; n++) begin
      b        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 7) != 0);
      par_bad  = ($urandom_range(0, 5) == 0);
      gap      = $urandom_range(0, 20);
      tail     = 0;
      if (!stop_bit) begin
        tail = $urandom_range(0, 30);
        if (gap < 2) gap = 2;
      end
      send_frame(b, stop_bit, par_bad, tail, gap);
    end
    settle("random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
